// File: rtl/rename_reg_file_pkg.sv
// rename_reg_file_pkg: shared defaults and constants for the rename register file
// Provides default widths/counts, the hardwired zero-register index and an address-width helper.
package rename_reg_file_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int TAG_W_DEF = 4;
  localparam int NRD_DEF = 2;
  localparam int ZERO_REG = 0;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rename_reg_file_if.sv
// rename_reg_file_if: issue/commit/read bundle of the rename register file
// master drives rdy_in, flush_in, iss_*, cmt_*, rd_en, rd_addr; slave drives rd_data, rd_busy, rd_tag, busy_cnt.
interface rename_reg_file_if
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD = NRD_DEF
) ();
  localparam int AW = addr_w(NREG);
  localparam int CW = $clog2(NREG + 1);
  logic rdy_in;
  logic flush_in;
  logic iss_en;
  logic [AW-1:0] iss_rd;
  logic [TAG_W-1:0] iss_tag;
  logic cmt_en;
  logic [AW-1:0] cmt_rd;
  logic [TAG_W-1:0] cmt_tag;
  logic [XLEN-1:0] cmt_data;
  logic [NRD-1:0] rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [CW-1:0] busy_cnt;
  modport master (
    output rdy_in, flush_in, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_data, rd_en, rd_addr,
    input rd_data, rd_busy, rd_tag, busy_cnt
  );
  modport slave (
    input rdy_in, flush_in, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_data, rd_en, rd_addr,
    output rd_data, rd_busy, rd_tag, busy_cnt
  );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the rename register file
// Ports: en/addr request; data_q/busy_q/tag_q stored state; wr/wr_rd/wr_data/clr commit view; data/busy/tag result.
// Macro RF_BYPASS_EN forwards a same-cycle commit to the read result.
module rf_read_port
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int AW = addr_w(NREG_DEF)
) (
  input  logic en,
  input  logic [AW-1:0] addr,
  input  logic [XLEN-1:0] data_q [NREG],
  input  logic [NREG-1:0] busy_q,
  input  logic [TAG_W-1:0] tag_q [NREG],
  input  logic wr,
  input  logic [AW-1:0] wr_rd,
  input  logic [XLEN-1:0] wr_data,
  input  logic clr,
  output logic [XLEN-1:0] data,
  output logic busy,
  output logic [TAG_W-1:0] tag
);
  logic live;
  assign live = en && addr != AW'(ZERO_REG);
`ifdef RF_BYPASS_EN
  logic hit;
  assign hit = live && wr && addr == wr_rd;
  assign data = !live ? '0 : hit ? wr_data : data_q[addr];
  assign busy = live && busy_q[addr] && !(hit && clr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr, wr_rd, wr_data, clr};
  assign data = live ? data_q[addr] : '0;
  assign busy = live && busy_q[addr];
`endif
  assign tag = live ? tag_q[addr] : '0;
endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with per-register busy bit and ROB tag
// Ports: clk_in, rst_in (async, active high); bus (slave) carries stall, flush, issue, commit, reads and busy_cnt.
// Macro RF_BYPASS_EN enables same-cycle commit forwarding on the read ports.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD = NRD_DEF
) (
  input logic clk_in,
  input logic rst_in,
  rename_reg_file_if.slave bus
);
  localparam int AW = addr_w(NREG);
  localparam int CW = $clog2(NREG + 1);
  logic [XLEN-1:0] data_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [NREG-1:0] busy_q, busy_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic iss_ok, cmt_wr, cmt_clr;
  assign iss_ok = bus.iss_en && bus.rdy_in && !bus.flush_in && bus.iss_rd != AW'(ZERO_REG);
  // a flush still lets a pending commit land its data even while stalled
  assign cmt_wr = bus.cmt_en && (bus.rdy_in || bus.flush_in) && bus.cmt_rd != AW'(ZERO_REG);
  // only the youngest in-flight writer may clear busy; a same-cycle rename keeps it busy
  assign cmt_clr = cmt_wr && bus.rdy_in && busy_q[bus.cmt_rd] && tag_q[bus.cmt_rd] == bus.cmt_tag &&
                   !(iss_ok && bus.iss_rd == bus.cmt_rd);
  always_comb begin
    busy_nxt = busy_q;
    if (cmt_clr) busy_nxt[bus.cmt_rd] = 1'b0;
    if (iss_ok) busy_nxt[bus.iss_rd] = 1'b1;
    if (bus.flush_in) busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q <= cnt_nxt;
      if (cmt_wr) data_q[bus.cmt_rd] <= bus.cmt_data;
      if (iss_ok) tag_q[bus.iss_rd] <= bus.iss_tag;
    end
  end
  assign bus.busy_cnt = cnt_q;
  for (genvar p = 0; p < NRD; p++) begin : g_port
    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .AW(AW)) u_port (
      .en(bus.rd_en[p]),
      .addr(bus.rd_addr[p*AW +: AW]),
      .data_q(data_q),
      .busy_q(busy_q),
      .tag_q(tag_q),
      .wr(cmt_wr),
      .wr_rd(bus.cmt_rd),
      .wr_data(bus.cmt_data),
      .clr(cmt_clr),
      .data(bus.rd_data[p*XLEN +: XLEN]),
      .busy(bus.rd_busy[p]),
      .tag(bus.rd_tag[p*TAG_W +: TAG_W])
    );
  end
endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; AW = $clog2(NREG).
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 SHALL have parameter NRD, default 2, read-port count.
REQ-005 SHALL have one clock and asynchronous active-high reset as ports clk_in (in, 1) and rst_in (in, 1), listed first.
REQ-006 SHALL have rdy_in, in, 1, global stall; issue/commit updates only when high.
REQ-007 SHALL have flush_in, in, 1, misprediction flush from commit stage.
REQ-008 SHALL have iss_en, in, 1; iss_rd, in, AW; iss_tag, in, TAG_W: rename destination at issue.
REQ-009 SHALL have cmt_en, in, 1; cmt_rd, in, AW; cmt_tag, in, TAG_W; cmt_data, in, XLEN: retirement write.
REQ-010 SHALL have rd_en, in, NRD; rd_addr, in, NRD*AW: packed read requests.
REQ-011 SHALL have rd_data, out, NRD*XLEN; rd_busy, out, NRD; rd_tag, out, NRD*TAG_W: packed read results.
REQ-012 SHALL have busy_cnt, out, $clog2(NREG+1), registered count of busy registers.

Function
REQ-013 SHALL hold per register: data (XLEN), busy bit, tag (TAG_W); busy replaces any sentinel tag value.
REQ-014 SHALL treat register 0 as hardwired: never written, never busy, reads data 0, busy 0, tag 0.
REQ-015 SHALL, on issue (iss_en, rdy_in, !flush_in, iss_rd!=0), set busy[iss_rd]=1, tag[iss_rd]=iss_tag at next edge.
REQ-016 SHALL, on commit (cmt_en, rdy_in, cmt_rd!=0), write data[cmt_rd]=cmt_data unconditionally.
REQ-017 SHALL clear busy[cmt_rd] on commit only if busy and tag[cmt_rd]==cmt_tag, and not renamed by issue in the same cycle.
REQ-018 SHALL, when iss_rd==cmt_rd on the same edge, write commit data and apply issue's busy/tag (issue wins status).
REQ-019 SHALL, on flush_in, clear all busy bits at next edge regardless of rdy_in, ignore issue, and still perform a pending commit data write if cmt_en.
REQ-020 SHALL, with rdy_in low and flush_in low, keep all state unchanged.
REQ-021 SHALL provide reads combinationally per port; port with rd_en[i]=0 outputs all zeros.
REQ-022 SHALL update busy_cnt on the same edge as busy bits so it always equals the popcount of busy registers; 0 after flush.

Reset
REQ-023 SHALL, on rst_in high, asynchronously clear all data, busy, tags and busy_cnt to 0; reset overrides flush, issue and commit.
REQ-024 SHALL resume normal operation on the first clk_in edge after rst_in deasserts.

Configuration
REQ-025 SHALL support macro RF_BYPASS_EN.
REQ-026 With RF_BYPASS_EN defined, a read of cmt_rd during a qualifying commit SHALL return cmt_data, and rd_busy=0 when REQ-017 clearing would occur; same-cycle issue to that register is not forwarded.
REQ-027 Without RF_BYPASS_EN, reads SHALL return pre-edge stored state only (one-cycle visibility latency).

Structure
REQ-028 SHALL take XLEN, AW-derived register-address width, TAG_W defaults and the zero-register constant from the shared definitions include.
REQ-029 SHALL implement each read port as sub-module rf_read_port (address decode, enable gating, optional bypass), instantiated NRD times by generate.

Verification
REQ-030 Reset then read r5 on port 0 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-031 Issue r5 tag 3; next cycle commit r5 tag 3 data 0xDEADBEEF -> after commit edge r5 busy=0, data 0xDEADBEEF, busy_cnt 1->0.
REQ-032 Issue r5 tag 3, issue r5 tag 7, commit r5 tag 3 data 0x11 -> data 0x11, busy stays 1, tag 7.
REQ-033 Same cycle issue r6 tag 2 and commit r6 tag 1 data 0x22 (r6 busy tag 1) -> data 0x22, busy 1, tag 2.
REQ-034 Three registers busy; flush_in with commit r8 data 0x33, rdy_in low -> all busy 0, r8=0x33, busy_cnt 0; issue r0 -> no change.
REQ-035 RF_BYPASS_EN: read r9 while committing r9 matching tag data 0x44 -> same-cycle rd_data 0x44, rd_busy 0; without macro -> old value until next cycle.
